// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM state type and the alignment predicate.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's load/store port (master) and
// the memory responder (slave).
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane steering: merges store data into the old word and
// extracts/extends load data from it.
module lsu_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data
);

  logic [31:0] byte_sh_s;
  logic [31:0] half_sh_s;

  assign byte_sh_s = old_word >> {addr_lo, 3'b000};
  assign half_sh_s = old_word >> {addr_lo[1], 4'b0000};

  // Lane merge for stores and lane extract plus extension for loads.
  always_comb begin
    wr_word = old_word;
    ld_data = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        wr_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        ld_data = is_unsigned ? {24'h00_0000, byte_sh_s[7:0]}
                              : {{24{byte_sh_s[7]}}, byte_sh_s[7:0]};
      end
      SZ_HALF: begin
        wr_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        ld_data = is_unsigned ? {16'h0000, half_sh_s[15:0]}
                              : {{16{half_sh_s[15]}}, half_sh_s[15:0]};
      end
      SZ_WORD: begin
        wr_word = wdata;
        ld_data = old_word;
      end
      default: begin
        wr_word = old_word;
        ld_data = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data port: one request at a time,
// WAIT_CYCLES wait states, byte/half/word access with error reporting.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [31:0]     offset_s;
  logic            in_range_s;
  logic            acc_err_s;
  logic [IW-1:0]   mem_idx_s;
  logic [31:0]     old_word_s;
  logic [31:0]     wr_word_s;
  logic [31:0]     ld_data_s;
  logic            mem_we_s;

  // Range check works on the 32-bit offset; a base above addr is an underflow.
  assign offset_s   = addr_q - ADDR_BASE;
  assign in_range_s = (addr_q >= ADDR_BASE) && ((offset_s >> 2) < 32'(DEPTH_WORDS));
  assign acc_err_s  = (size_q == SZ_ILL) || is_misaligned(size_q, addr_q[1:0]) || !in_range_s;
  assign mem_idx_s  = IW'(offset_s >> 2);
  assign old_word_s = in_range_s ? mem_q[mem_idx_s] : 32'h0000_0000;

  lsu_lane_align u_align (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .old_word    (old_word_s),
    .wr_word     (wr_word_s),
    .ld_data     (ld_data_s)
  );

  // Next-state and next-output logic; storage is touched only on the commit edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    mem_we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d        = bus.req_we;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          size_d      = bus.req_size;
          uns_d       = bus.req_unsigned;
          cnt_d       = WAIT_LOAD;
          req_ready_d = 1'b0;
          state_d     = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(0)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          if (acc_err_s) begin
            rdata_d = 32'h0000_0000;
            err_d   = 1'b1;
          end else if (we_q) begin
            mem_we_s = 1'b1;
            rdata_d  = 32'h0000_0000;
            err_d    = 1'b0;
          end else begin
            rdata_d = ld_data_s;
            err_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          rdata_d     = 32'h0000_0000;
          err_d       = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = CW'(0);
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        rdata_d     = 32'h0000_0000;
        err_d       = 1'b0;
      end
    endcase
  end

  // Control and response registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= CW'(0);
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Storage keeps its contents across reset; an abandoned request never reaches WAIT's commit.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_idx_s] <= wr_word_s;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed table, backpressure/reset sequences, random
// traffic against a byte-array model, and a zero-wait-state instance.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if m0 ();
  data_mem_responder_if m1 ();

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .ADDR_BASE(32'h0000_0000))
    dut0 (.clk(clk), .rst(rst), .bus(m0.slave));

  data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .ADDR_BASE(32'h0000_0100))
    dut1 (.clk(clk), .rst(rst), .bus(m1.slave));

  int checks = 0;
  int failures = 0;
  logic [7:0] mdl [0:4095];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference rules for DUT0 (base 0, 1024 words), expressed on byte addresses.
  function automatic bit mdl_err(input logic [31:0] a, input logic [1:0] s);
    longint off;
    int nb;
    if (s == 2'd3) return 1'b1;
    nb = 1 << s;
    if ((a % nb) != 0) return 1'b1;
    off = longint'(a) - 64'sd0;
    if (off < 0) return 1'b1;
    if (off / 4 >= 1024) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void mdl_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    for (int k = 0; k < (1 << s); k++) mdl[a + k] = d[8*k +: 8];
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] s, input logic uns);
    longint v;
    int nb;
    v = 0;
    nb = 1 << s;
    for (int k = 0; k < nb; k++) v += longint'(mdl[a + k]) << (8 * k);
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    return v[31:0];
  endfunction

  // One full transaction with bp cycles of response backpressure.
  task automatic txn(input virtual data_mem_responder_if vif, input string tag,
                     input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns, input int bp, input int exp_lat,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int lat;
    n = 0;
    while (vif.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, ".req_ready"}, 32'(vif.req_ready), 32'h1);
    vif.req_valid    = 1'b1;
    vif.req_we       = we;
    vif.req_addr     = addr;
    vif.req_wdata    = wdata;
    vif.req_size     = size;
    vif.req_unsigned = uns;
    vif.rsp_ready    = 1'b0;
    @(posedge clk); #1;
    vif.req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (vif.rsp_valid !== 1'b1 && lat < 20);
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, vif.rsp_rdata, exp_rdata);
    chk({tag, ".err"}, 32'(vif.rsp_err), 32'(exp_err));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk({tag, ".bp_valid"}, 32'(vif.rsp_valid), 32'h1);
      chk({tag, ".bp_rdata"}, vif.rsp_rdata, exp_rdata);
    end
    vif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    vif.rsp_ready = 1'b0;
    chk({tag, ".done_valid"}, 32'(vif.rsp_valid), 32'h0);
  endtask

  initial begin
    logic [31:0] a, d, er;
    logic [1:0]  s;
    logic        w, u, e;
    logic [5:0]  rr_pat, rv_pat;
    int          n;

    m0.req_valid = 1'b0; m0.req_we = 1'b0; m0.req_addr = 32'h0; m0.req_wdata = 32'h0;
    m0.req_size = SZ_BYTE; m0.req_unsigned = 1'b0; m0.rsp_ready = 1'b0;
    m1.req_valid = 1'b0; m1.req_we = 1'b0; m1.req_addr = 32'h0; m1.req_wdata = 32'h0;
    m1.req_size = SZ_BYTE; m1.req_unsigned = 1'b0; m1.rsp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;

    vt[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, SZ_WORD, 1'b0, 32'h0000_0000, 1'b0};
    vt[1]  = '{1'b0, 32'h10,   32'h0,        SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h11,   32'hFFFFFF80, SZ_BYTE, 1'b0, 32'h0000_0000, 1'b0};
    vt[3]  = '{1'b0, 32'h11,   32'h0,        SZ_BYTE, 1'b0, 32'hFFFFFF80, 1'b0};
    vt[4]  = '{1'b0, 32'h11,   32'h0,        SZ_BYTE, 1'b1, 32'h0000_0080, 1'b0};
    vt[5]  = '{1'b0, 32'h12,   32'h0,        SZ_HALF, 1'b0, 32'hFFFFDEAD, 1'b0};
    vt[6]  = '{1'b0, 32'h10,   32'h0,        SZ_WORD, 1'b0, 32'hDEAD80EF, 1'b0};
    vt[7]  = '{1'b1, 32'h12,   32'h11111111, SZ_WORD, 1'b0, 32'h0000_0000, 1'b1};
    vt[8]  = '{1'b1, 32'h13,   32'h00002222, SZ_HALF, 1'b0, 32'h0000_0000, 1'b1};
    vt[9]  = '{1'b0, 32'h1000, 32'h0,        SZ_WORD, 1'b0, 32'h0000_0000, 1'b1};
    vt[10] = '{1'b0, 32'h10,   32'h0,        SZ_ILL,  1'b0, 32'h0000_0000, 1'b1};
    vt[11] = '{1'b1, 32'h10,   32'h33333333, SZ_ILL,  1'b0, 32'h0000_0000, 1'b1};
    vt[12] = '{1'b0, 32'h10,   32'h0,        SZ_WORD, 1'b0, 32'hDEAD80EF, 1'b0};
    vt[13] = '{1'b1, 32'hFFC,  32'h0BADF00D, SZ_WORD, 1'b0, 32'h0000_0000, 1'b0};
    vt[14] = '{1'b0, 32'hFFE,  32'h0,        SZ_HALF, 1'b1, 32'h0000_0BAD, 1'b0};

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", 32'(m0.req_ready), 32'h1);
    chk("rst.rsp_valid", 32'(m0.rsp_valid), 32'h0);
    chk("rst.rsp_rdata", m0.rsp_rdata, 32'h0);
    chk("rst.rsp_err", 32'(m0.rsp_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.req_ready", 32'(m0.req_ready), 32'h1);
    chk("post_rst.rsp_valid", 32'(m0.rsp_valid), 32'h0);

    // Known contents for the region used by random traffic
    for (int i = 0; i < 16; i++) begin
      d = {8'hA5, 8'(i), 16'h5A3C};
      txn(m0, "prefill", 1'b1, 32'(4 * i), d, SZ_WORD, 1'b0, 0, 3, 32'h0, 1'b0);
      mdl_store(32'(4 * i), d, SZ_WORD);
    end

    // Directed table
    for (int i = 0; i < 15; i++) begin
      txn(m0, $sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].wdata, vt[i].size,
          vt[i].uns, i % 3, 3, vt[i].exp_rdata, vt[i].exp_err);
      if (vt[i].we && !mdl_err(vt[i].addr, vt[i].size)) mdl_store(vt[i].addr, vt[i].wdata, vt[i].size);
    end

    // Backpressure with req_valid held high throughout
    m0.req_valid = 1'b1; m0.req_we = 1'b0; m0.req_addr = 32'h10;
    m0.req_size = SZ_WORD; m0.req_unsigned = 1'b0; m0.rsp_ready = 1'b0;
    @(posedge clk); #1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (m0.rsp_valid !== 1'b1 && n < 20);
    chk("bp.latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp.rsp_valid", 32'(m0.rsp_valid), 32'h1);
      chk("bp.rsp_rdata", m0.rsp_rdata, 32'hDEAD80EF);
      chk("bp.req_ready", 32'(m0.req_ready), 32'h0);
      @(posedge clk); #1;
    end
    m0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    m0.rsp_ready = 1'b0;
    chk("bp.hs_req_ready", 32'(m0.req_ready), 32'h1);
    chk("bp.hs_rsp_valid", 32'(m0.rsp_valid), 32'h0);
    @(posedge clk); #1;
    m0.req_valid = 1'b0;
    chk("bp.reaccept", 32'(m0.req_ready), 32'h0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (m0.rsp_valid !== 1'b1 && n < 20);
    chk("bp.second_rdata", m0.rsp_rdata, 32'hDEAD80EF);
    m0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    m0.rsp_ready = 1'b0;

    // Reset during WAIT abandons the store
    m0.req_valid = 1'b1; m0.req_we = 1'b1; m0.req_addr = 32'h20;
    m0.req_wdata = 32'h12345678; m0.req_size = SZ_WORD;
    @(posedge clk); #1;
    m0.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst.req_ready", 32'(m0.req_ready), 32'h1);
    chk("midrst.rsp_valid", 32'(m0.rsp_valid), 32'h0);
    chk("midrst.rsp_rdata", m0.rsp_rdata, 32'h0);
    chk("midrst.rsp_err", 32'(m0.rsp_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    txn(m0, "midrst.load", 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 0, 3, mdl_load(32'h20, SZ_WORD, 1'b0), 1'b0);

    // Random traffic against the byte model
    for (int i = 0; i < 200; i++) begin
      n = int'($urandom_range(0, 9));
      if (n < 7)      a = 32'($urandom_range(0, 63));
      else if (n < 9) a = 32'h1000 + 32'($urandom_range(0, 7));
      else            a = 32'hFFFF_FFFC;
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      u = 1'($urandom_range(0, 1));
      d = $urandom;
      e = mdl_err(a, s);
      er = (e || w) ? 32'h0 : mdl_load(a, s, u);
      txn(m0, "rand", w, a, d, s, u, int'($urandom_range(0, 2)), 3, er, e);
      if (w && !e) mdl_store(a, d, s);
    end

    // Zero wait states: back-to-back with rsp_ready tied high
    rr_pat = 6'b100100;
    rv_pat = 6'b010010;
    m1.req_valid = 1'b1; m1.req_we = 1'b1; m1.req_addr = 32'h104;
    m1.req_wdata = 32'hCAFEF00D; m1.req_size = SZ_WORD; m1.rsp_ready = 1'b1;
    chk("w0.idle_ready", 32'(m1.req_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("w0.req_ready%0d", i), 32'(m1.req_ready), 32'(rr_pat[i]));
      chk($sformatf("w0.rsp_valid%0d", i), 32'(m1.rsp_valid), 32'(rv_pat[i]));
    end
    m1.req_valid = 1'b0;
    m1.rsp_ready = 1'b0;
    txn(m1, "w0.load",      1'b0, 32'h104, 32'h0,  SZ_WORD, 1'b0, 1, 1, 32'hCAFEF00D, 1'b0);
    txn(m1, "w0.underflow", 1'b0, 32'h0FC, 32'h0,  SZ_WORD, 1'b0, 0, 1, 32'h0, 1'b1);
    txn(m1, "w0.past_end",  1'b0, 32'h140, 32'h0,  SZ_WORD, 1'b0, 0, 1, 32'h0, 1'b1);
    txn(m1, "w0.st_b3",     1'b1, 32'h13F, 32'h5A, SZ_BYTE, 1'b0, 0, 1, 32'h0, 1'b0);
    txn(m1, "w0.st_b2",     1'b1, 32'h13E, 32'hC3, SZ_BYTE, 1'b0, 0, 1, 32'h0, 1'b0);
    txn(m1, "w0.ld_b3",     1'b0, 32'h13F, 32'h0,  SZ_BYTE, 1'b0, 0, 1, 32'h0000005A, 1'b0);
    txn(m1, "w0.ld_h",      1'b0, 32'h13E, 32'h0,  SZ_HALF, 1'b0, 0, 1, 32'h00005AC3, 1'b0);
    txn(m1, "w0.ld_b2s",    1'b0, 32'h13E, 32'h0,  SZ_BYTE, 1'b0, 0, 1, 32'hFFFFFFC3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
